// File: rtl/psoa_sigmoid.sv
// Piecewise quadratic logistic-sigmoid for non-negative Q6.10 input, one-cycle registered output.
// f(x) = 1 - 0.5*(1 - x/4)^2 below 4.0, saturating to 1.0 at and above 4.0.
module psoa_sigmoid (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x,
    output logic [15:0] f_x
);

    logic        sat_s;
    logic [10:0] u_s;
    logic [21:0] p_s;
    logic [10:0] p_hi_s;
    logic [15:0] f_x_d;
    logic [15:0] f_x_q;

    // Quadratic segment and saturation select for the current sample
    always_comb begin
        sat_s  = (x[15:12] != 4'd0);
        u_s    = 11'd1024 - 11'(x[11:0] >> 2);
        p_s    = {11'd0, u_s} * {11'd0, u_s};
        // P peaks at 2^20, so P >> 11 never exceeds 512 and F never underflows
        p_hi_s = 11'(p_s >> 11);
        if (sat_s) begin
            f_x_d = 16'd1024;
        end else begin
            f_x_d = 16'd1024 - {5'd0, p_hi_s};
        end
    end

    // Output register, cleared asynchronously by active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_x_q <= 16'd0;
        end else begin
            f_x_q <= f_x_d;
        end
    end

    assign f_x = f_x_q;

endmodule

// File: tb/tb_psoa_sigmoid.sv
// Self-checking bench for psoa_sigmoid: directed table, latency, reset, and accuracy sweep.
module tb_psoa_sigmoid;

    logic        clk;
    logic        reset;
    logic [15:0] x;
    logic [15:0] f_x;

    int checks;
    int errors;

    psoa_sigmoid dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .f_x   (f_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] f;
    } vec_t;

    // Reference: 1 - (1 - X/4096)^2 / 2 scaled by 1024, truncating, saturating at 4.0
    function automatic int model(input int xv);
        int u;
        if (xv >= 4096) return 1024;
        u = 1024 - xv / 4;
        return 1024 - (u * u) / 2048;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t  tbl[10];
        int    prev_x;
        int    r;
        int    xi;
        int    fv;
        int    prev_f;
        int    n;
        real   xr;
        real   err;
        real   max_err;
        real   sum_err;

        checks = 0;
        errors = 0;

        tbl[0] = '{16'd0,     16'd512};
        tbl[1] = '{16'd2048,  16'd896};
        tbl[2] = '{16'd1024,  16'd736};
        tbl[3] = '{16'd4095,  16'd1024};
        tbl[4] = '{16'd4096,  16'd1024};
        tbl[5] = '{16'd8192,  16'd1024};
        tbl[6] = '{16'd65535, 16'd1024};
        tbl[7] = '{16'd1,     16'd512};
        tbl[8] = '{16'd4,     16'd513};
        tbl[9] = '{16'd3072,  16'd992};

        // Reset held with clock running
        reset = 1'b0;
        x     = 16'd1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", int'(f_x), 0);
        end

        reset = 1'b1;
        x     = 16'd0;
        @(posedge clk);
        #1;
        check("first_after_reset", int'(f_x), 512);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            x = tbl[i].x;
            @(posedge clk);
            #1;
            check($sformatf("table[%0d] x=%0d", i, tbl[i].x), int'(f_x), int'(tbl[i].f));
        end

        // Asynchronous clear from a non-zero output, between edges
        x = 16'd2048;
        @(posedge clk);
        #2;
        check("pre_async", int'(f_x), 896);
        reset = 1'b0;
        #1;
        check("async_clear", int'(f_x), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("after_async", int'(f_x), 896);

        // Latency: output tracks the previous edge's sample, not the current input
        prev_x = 2048;
        for (int i = 0; i < 200; i++) begin
            r = (i % 4 == 0) ? int'($urandom_range(65535, 0)) : int'($urandom_range(4200, 0));
            x = 16'(r);
            #2;
            check("latency_hold", int'(f_x), model(prev_x));
            @(posedge clk);
            #1;
            check("random", int'(f_x), model(r));
            prev_x = r;
        end

        // Accuracy and monotonicity sweep over |x| in [0,8], with a reset pulse midway
        max_err = 0.0;
        sum_err = 0.0;
        n       = 0;
        prev_f  = 0;
        for (int k = 0; k <= 500; k++) begin
            xr = k * 0.016;
            xi = $rtoi(xr * 1024.0 + 0.5);
            x  = 16'(xi);
            if (k == 250) begin
                #2;
                reset = 1'b0;
                #1;
                check("sweep_reset_async", int'(f_x), 0);
                @(posedge clk);
                #1;
                check("sweep_reset_edge", int'(f_x), 0);
                @(negedge clk);
                reset = 1'b1;
            end
            @(posedge clk);
            #1;
            fv = int'(f_x);
            check("sweep_value", fv, model(xi));
            check("sweep_upper_bits", int'(f_x[15:11] != 5'd0 && fv != 1024), 0);
            if (k > 0) begin
                check("monotonic", int'(fv < prev_f), 0);
            end
            prev_f = fv;
            xr  = xi / 1024.0;
            err = fv / 1024.0 - 1.0 / (1.0 + $exp(-xr));
            if (err < 0.0) err = -err;
            if (err > max_err) max_err = err;
            sum_err += err;
            n++;
            err = (1.0 - fv / 1024.0) - 1.0 / (1.0 + $exp(xr));
            if (err < 0.0) err = -err;
            if (err > max_err) max_err = err;
            sum_err += err;
            n++;
        end
        check("max_err_le_0.025", int'(max_err > 0.025), 0);
        check("mean_err_le_0.012", int'((sum_err / n) > 0.012), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
